// File: rtl/rca_serial_subtractor.sv
// Bit-serial subtractor: recovers b = sum - sext(a), LSB first, through one full-subtractor cell.
// Optional build macro RCA_SUB_SAT_EN saturates b to the signed extreme when the result overflows.
module rca_serial_subtractor #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH:0]   sum,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nx;
    logic [WIDTH:0]   sreg, areg, dreg, dfull;
    logic [CW-1:0]    cnt;
    logic             borrow, borrow_nx, d_bit, last, ovf_nx;
    logic [WIDTH-1:0] b_nx;

    // Single full-subtractor slice working on the current LSB of each operand.
    assign d_bit     = sreg[0] ^ areg[0] ^ borrow;
    assign borrow_nx = (~sreg[0] & areg[0]) | (~(sreg[0] ^ areg[0]) & borrow);
    assign dfull     = {d_bit, dreg[WIDTH:1]};
    assign last      = (cnt == CW'(WIDTH));
    assign ovf_nx    = dfull[WIDTH] ^ dfull[WIDTH-1];

    always_comb begin
        b_nx = dfull[WIDTH-1:0];
`ifdef RCA_SUB_SAT_EN
        if (ovf_nx) b_nx = {dfull[WIDTH], {(WIDTH-1){~dfull[WIDTH]}}};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg     <= '0;
            areg     <= '0;
            dreg     <= '0;
            cnt      <= '0;
            borrow   <= 1'b0;
            b        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg     <= sum;
                        areg     <= {a[WIDTH-1], a};
                        dreg     <= '0;
                        cnt      <= '0;
                        borrow   <= 1'b0;
                        busy     <= 1'b1;
                        b        <= '0;
                        overflow <= 1'b0;
                    end
                end
                SHIFT: begin
                    sreg   <= sreg >> 1;
                    areg   <= areg >> 1;
                    dreg   <= dfull;
                    borrow <= borrow_nx;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        b        <= b_nx;
                        overflow <= ovf_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
